// File: rtl/topk_stream_sorter_if.sv
// topk_stream_sorter_if: beat input and top-K result handshakes of the streaming sorter
interface topk_stream_sorter_if #(
  parameter int VAL_W = 24,
  parameter int ID_W  = 6,
  parameter int K     = 10,
  parameter int LANES = 4
);
  logic                     in_valid;
  logic                     in_ready;
  logic [LANES*VAL_W-1:0]   in_vals;
  logic [LANES*ID_W-1:0]    in_ids;
  logic [LANES-1:0]         in_lane_en;
  logic                     in_last;
  logic                     out_valid;
  logic                     out_ready;
  logic [K*VAL_W-1:0]       top_vals;
  logic [K*ID_W-1:0]        top_ids;
  logic [$clog2(K+1)-1:0]   top_count;
  modport master (
    output in_valid, in_vals, in_ids, in_lane_en, in_last, out_ready,
    input  in_ready, out_valid, top_vals, top_ids, top_count
  );
  modport slave (
    input  in_valid, in_vals, in_ids, in_lane_en, in_last, out_ready,
    output in_ready, out_valid, top_vals, top_ids, top_count
  );
endinterface

// File: rtl/topk_stream_sorter.sv
// topk_stream_sorter: keeps the K largest (value, ID) pairs of a frame sorted by insertion, one lane per cycle
module topk_stream_sorter #(
  parameter int VAL_W = 24,
  parameter int ID_W  = 6,
  parameter int K     = 10,
  parameter int LANES = 4
) (
  input logic clk_i,
  input logic reset_i,
  topk_stream_sorter_if.slave io
);
  localparam int CW = $clog2(K + 1);
  localparam int LW = LANES > 1 ? $clog2(LANES) : 1;
  typedef enum logic [1:0] {ACCEPT, INSERT, DONE} state_t;
  state_t state_q, state_d;
  logic [VAL_W-1:0] hv_q [LANES];
  logic [ID_W-1:0]  hi_q [LANES];
  logic [LANES-1:0] he_q;
  logic             hl_q;
  logic [LW-1:0]    lane_q;
  logic [VAL_W-1:0] val_q [K];
  logic [VAL_W-1:0] val_d [K];
  logic [ID_W-1:0]  id_q [K];
  logic [ID_W-1:0]  id_d [K];
  logic [CW-1:0]    cnt_q, cnt_d, pos;
  logic [VAL_W-1:0] v;
  logic [ID_W-1:0]  nid;
  logic             ins, clr;
  always_ff @(posedge clk_i)
    if (reset_i) state_q <= ACCEPT;
    else state_q <= state_d;
  always_comb
    state_d = state_q == ACCEPT ? (io.in_valid ? INSERT : ACCEPT) :
              state_q == INSERT ? (lane_q == LW'(LANES - 1) ? (hl_q ? DONE : ACCEPT) : INSERT) :
              (io.out_ready ? ACCEPT : DONE);
  always_comb begin
    io.in_ready  = state_q == ACCEPT;
    io.out_valid = state_q == DONE;
    io.top_count = cnt_q;
  end
  // The table is sorted descending, so the >= matches form a prefix and their count is the slot;
  // ">=" puts a new equal value behind earlier arrivals.
  always_comb begin
    v   = hv_q[lane_q];
    nid = hi_q[lane_q];
    pos = '0;
    for (int s = 0; s < K; s++)
      if (CW'(s) < cnt_q && val_q[s] >= v) pos = pos + CW'(1);
  end
  always_comb begin
    ins   = state_q == INSERT && he_q[lane_q] && pos < CW'(K);
    clr   = state_q == DONE && io.out_ready;
    cnt_d = clr ? '0 : (ins && cnt_q != CW'(K)) ? cnt_q + CW'(1) : cnt_q;
    for (int s = 0; s < K; s++) begin
      val_d[s] = clr ? '0 : (!ins || CW'(s) < pos) ? val_q[s] : CW'(s) == pos ? v : val_q[s == 0 ? 0 : s - 1];
      id_d[s]  = clr ? '0 : (!ins || CW'(s) < pos) ? id_q[s] : CW'(s) == pos ? nid : id_q[s == 0 ? 0 : s - 1];
    end
  end
  always_ff @(posedge clk_i)
    if (reset_i) begin
      cnt_q  <= '0;
      lane_q <= '0;
      he_q   <= '0;
      hl_q   <= 1'b0;
      for (int s = 0; s < K; s++) begin
        val_q[s] <= '0;
        id_q[s]  <= '0;
      end
      for (int l = 0; l < LANES; l++) begin
        hv_q[l] <= '0;
        hi_q[l] <= '0;
      end
    end else begin
      cnt_q <= cnt_d;
      for (int s = 0; s < K; s++) begin
        val_q[s] <= val_d[s];
        id_q[s]  <= id_d[s];
      end
      if (state_q == ACCEPT && io.in_valid) begin
        lane_q <= '0;
        he_q   <= io.in_lane_en;
        hl_q   <= io.in_last;
        for (int l = 0; l < LANES; l++) begin
          hv_q[l] <= io.in_vals[l*VAL_W +: VAL_W];
          hi_q[l] <= io.in_ids[l*ID_W +: ID_W];
        end
      end else if (state_q == INSERT) lane_q <= lane_q + LW'(1);
    end
  for (genvar j = 0; j < K; j++) begin : g_out
    assign io.top_vals[j*VAL_W +: VAL_W] = val_q[j];
    assign io.top_ids[j*ID_W +: ID_W]    = id_q[j];
  end
endmodule

// File: tb/tb_topk_stream_sorter.sv
// tb_topk_stream_sorter: directed table-driven checks of the streaming top-K sorter
module tb_topk_stream_sorter;
  localparam int VAL_W = 24, ID_W = 6, K = 10, LANES = 4;
  typedef logic [LANES-1:0][VAL_W-1:0] lv_t;
  typedef logic [LANES-1:0][ID_W-1:0]  li_t;
  typedef logic [K-1:0][VAL_W-1:0]     kv_t;
  typedef logic [K-1:0][ID_W-1:0]      ki_t;
  typedef struct {
    lv_t v; li_t id; logic [LANES-1:0] en;
    kv_t ev; ki_t eid; int ecnt;
  } vec_t;
  logic clk = 0, rst = 1;
  int total = 0, passed = 0;
  vec_t tbl [4];
  kv_t sv, ev;
  ki_t si, ei;
  int bad;
  topk_stream_sorter_if #(.VAL_W(VAL_W), .ID_W(ID_W), .K(K), .LANES(LANES)) bus ();
  topk_stream_sorter #(.VAL_W(VAL_W), .ID_W(ID_W), .K(K), .LANES(LANES)) dut (
    .clk_i(clk), .reset_i(rst), .io(bus)
  );
  always #5 clk = ~clk;
  function automatic lv_t mkv(int a [LANES]);
    lv_t r;
    for (int i = 0; i < LANES; i++) r[i] = VAL_W'(a[i]);
    return r;
  endfunction
  function automatic li_t mki(int a [LANES]);
    li_t r;
    for (int i = 0; i < LANES; i++) r[i] = ID_W'(a[i]);
    return r;
  endfunction
  function automatic kv_t ekv(int a [K]);
    kv_t r;
    for (int i = 0; i < K; i++) r[i] = VAL_W'(a[i]);
    return r;
  endfunction
  function automatic ki_t eki(int a [K]);
    ki_t r;
    for (int i = 0; i < K; i++) r[i] = ID_W'(a[i]);
    return r;
  endfunction
  task automatic chk(string nm, logic [255:0] got, logic [255:0] exp);
    total++;
    if (got !== exp) $display("FAIL %s: got %0h, want %0h", nm, got, exp);
    else passed++;
  endtask
  task automatic check_table(string nm, kv_t v, ki_t id, int cnt);
    chk({nm, ".vals"}, 256'(bus.top_vals), 256'(v));
    chk({nm, ".ids"}, 256'(bus.top_ids), 256'(id));
    chk({nm, ".count"}, 256'(bus.top_count), 256'(cnt));
  endtask
  task automatic drive_beat(lv_t v, li_t id, logic [LANES-1:0] en, logic last);
    int n = 0;
    while (!bus.in_ready && n < 200) begin
      @(negedge clk);
      n++;
    end
    chk("ready_wait", 256'(bus.in_ready), 256'(1));
    bus.in_vals = v; bus.in_ids = id; bus.in_lane_en = en; bus.in_last = last;
    bus.in_valid = 1;
    @(posedge clk);
    @(negedge clk);
    bus.in_valid = 0;
  endtask
  task automatic run_beat(lv_t v, li_t id, logic [LANES-1:0] en, logic last);
    int busy = 0;
    drive_beat(v, id, en, last);
    for (int i = 0; i < LANES; i++) begin
      if (!bus.in_ready && !bus.out_valid) busy++;
      @(negedge clk);
    end
    chk("busy_cycles", 256'(busy), 256'(LANES));
    chk(last ? "out_valid_rise" : "in_ready_back", 256'(last ? bus.out_valid : bus.in_ready), 256'(1));
  endtask
  task automatic release_out();
    bus.out_ready = 1;
    @(posedge clk);
    @(negedge clk);
    bus.out_ready = 0;
    chk("rel.out_valid", 256'(bus.out_valid), 256'(0));
    chk("rel.in_ready", 256'(bus.in_ready), 256'(1));
    check_table("rel", '0, '0, 0);
  endtask
  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end
  initial begin
    bus.in_valid = 0; bus.in_vals = '0; bus.in_ids = '0; bus.in_lane_en = '0;
    bus.in_last = 0; bus.out_ready = 0;
    tbl[0] = '{mkv('{5, 9, 1, 7}), mki('{0, 1, 2, 3}), 4'hF,
               ekv('{9, 7, 5, 1, 0, 0, 0, 0, 0, 0}), eki('{1, 3, 0, 2, 0, 0, 0, 0, 0, 0}), 4};
    tbl[1] = '{mkv('{10, 20, 30, 40}), mki('{0, 1, 2, 3}), 4'b0101,
               ekv('{30, 10, 0, 0, 0, 0, 0, 0, 0, 0}), eki('{2, 0, 0, 0, 0, 0, 0, 0, 0, 0}), 2};
    tbl[2] = '{mkv('{1, 2, 3, 4}), mki('{1, 2, 3, 4}), 4'b0000, '0, '0, 0};
    tbl[3] = '{mkv('{0, 3, 0, 3}), mki('{4, 5, 6, 7}), 4'hF,
               ekv('{3, 3, 0, 0, 0, 0, 0, 0, 0, 0}), eki('{5, 7, 4, 6, 0, 0, 0, 0, 0, 0}), 4};
    repeat (3) @(negedge clk);
    chk("reset.in_ready", 256'(bus.in_ready), 256'(1));
    rst = 0;
    @(negedge clk);
    chk("reset.out_valid", 256'(bus.out_valid), 256'(0));
    check_table("reset", '0, '0, 0);
    // single-beat frames
    for (int t = 0; t < 4; t++) begin
      run_beat(tbl[t].v, tbl[t].id, tbl[t].en, 1'b1);
      check_table($sformatf("vec%0d", t), tbl[t].ev, tbl[t].eid, tbl[t].ecnt);
      release_out();
    end
    // 64 ascending values over 16 beats
    for (int b = 0; b < 16; b++)
      run_beat(mkv('{4*b, 4*b+1, 4*b+2, 4*b+3}), mki('{4*b, 4*b+1, 4*b+2, 4*b+3}), 4'hF, b == 15);
    for (int j = 0; j < K; j++) begin
      ev[j] = VAL_W'(63 - j);
      ei[j] = ID_W'(63 - j);
    end
    check_table("ascend", ev, ei, 10);
    release_out();
    // ties across and within beats; out_ready while idle is ignored
    run_beat(mkv('{8, 8, 3, 8}), mki('{1, 2, 3, 4}), 4'hF, 1'b0);
    bus.out_ready = 1;
    repeat (3) @(negedge clk);
    bus.out_ready = 0;
    chk("idle_out_ready.in_ready", 256'(bus.in_ready), 256'(1));
    run_beat(mkv('{8, 2, 2, 2}), mki('{5, 6, 7, 8}), 4'hF, 1'b1);
    check_table("ties", ekv('{8, 8, 8, 8, 3, 2, 2, 2, 0, 0}), eki('{1, 2, 4, 5, 3, 6, 7, 8, 0, 0}), 8);
    // backpressure with a pending beat that must be ignored
    sv = bus.top_vals; si = bus.top_ids; bad = 0;
    bus.in_vals = mkv('{63, 63, 63, 63}); bus.in_lane_en = 4'hF; bus.in_last = 1; bus.in_valid = 1;
    repeat (20) begin
      @(negedge clk);
      if (bus.top_vals !== sv || bus.top_ids !== si || bus.top_count !== 4'd8 || bus.in_ready || !bus.out_valid) bad++;
    end
    bus.in_valid = 0;
    chk("hold_stable", 256'(bad), 256'(0));
    release_out();
    run_beat(tbl[0].v, tbl[0].id, tbl[0].en, 1'b1);
    check_table("after_hold", tbl[0].ev, tbl[0].eid, tbl[0].ecnt);
    release_out();
    // reset during the third beat's insert
    run_beat(mkv('{50, 51, 52, 53}), mki('{1, 2, 3, 4}), 4'hF, 1'b0);
    run_beat(mkv('{40, 41, 42, 43}), mki('{5, 6, 7, 8}), 4'hF, 1'b0);
    drive_beat(mkv('{30, 31, 32, 33}), mki('{9, 10, 11, 12}), 4'hF, 1'b1);
    @(negedge clk);
    rst = 1;
    @(posedge clk);
    @(negedge clk);
    rst = 0;
    chk("midreset.in_ready", 256'(bus.in_ready), 256'(1));
    chk("midreset.out_valid", 256'(bus.out_valid), 256'(0));
    check_table("midreset", '0, '0, 0);
    run_beat(tbl[3].v, tbl[3].id, tbl[3].en, 1'b1);
    check_table("post_reset", tbl[3].ev, tbl[3].eid, tbl[3].ecnt);
    release_out();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
